lcg_ctrl: RTL

Linear congruential generator sequencer sitting directly upstream of the shared sequential multiplier (mult). Holds the generator state x, feeds A and x to the multiplier over its enable/done handshake, and captures the 2*WIDTH product. Computes x_next = (A*x + C) mod 2^WIDTH and presents each new value to the consumer over a valid/ready interface. The multiplier is instantiated beside this block at the level above, not inside it.

---
 rtl/lcg_ctrl_pkg.sv | 23 ++
 rtl/lcg_ctrl_if.sv | 28 ++
 rtl/lcg_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/lcg_ctrl_pkg.sv
// Shared definitions for the LCG sequencer: FSM encodings, default generator constants
// and a reference step function.
package lcg_ctrl_pkg;

  localparam int unsigned LCG_WIDTH = 4;

  localparam logic [LCG_WIDTH-1:0] LCG_A         = 4'd5;
  localparam logic [LCG_WIDTH-1:0] LCG_C         = 4'd3;
  localparam logic [LCG_WIDTH-1:0] LCG_SEED_INIT = 4'd7;

  localparam logic [1:0] StStart = 2'd0;
  localparam logic [1:0] StBusy  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StValid = 2'd3;

  // One generator step with the default constants, x_next = (A*x + C) mod 2^WIDTH.
  function automatic logic [LCG_WIDTH-1:0] lcg_next(input logic [LCG_WIDTH-1:0] x);
    logic [2*LCG_WIDTH-1:0] prod;
    prod = (2*LCG_WIDTH)'(LCG_A) * (2*LCG_WIDTH)'(x);
    return prod[LCG_WIDTH-1:0] + LCG_C;
  endfunction

endpackage

// File: rtl/lcg_ctrl_if.sv
// Seed, consumer and multiplier handshake signals of the LCG sequencer.
// The master side is the sequencer; the slave side is its environment.
interface lcg_ctrl_if #(
  parameter int unsigned WIDTH = 4
);

  logic                 seed_load;
  logic [WIDTH-1:0]     seed_data;
  logic                 rnd_valid;
  logic                 rnd_ready;
  logic [WIDTH-1:0]     rnd_data;
  logic [WIDTH-1:0]     mult_multiplicand;
  logic [WIDTH-1:0]     mult_multiplier;
  logic                 mult_enable;
  logic                 mult_done;
  logic [2*WIDTH-1:0]   mult_result;

  modport master (
    input  seed_load, seed_data, rnd_ready, mult_done, mult_result,
    output rnd_valid, rnd_data, mult_multiplicand, mult_multiplier, mult_enable
  );

  modport slave (
    output seed_load, seed_data, rnd_ready, mult_done, mult_result,
    input  rnd_valid, rnd_data, mult_multiplicand, mult_multiplier, mult_enable
  );

endinterface

// File: rtl/lcg_ctrl.sv
// LCG sequencer: drives an external shared multiplier with A and x, adds C to the low
// product bits and offers each new x to the consumer over valid/ready.
module lcg_ctrl
  import lcg_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH     = LCG_WIDTH,
  parameter logic [WIDTH-1:0] A         = LCG_A,
  parameter logic [WIDTH-1:0] C         = LCG_C,
  parameter logic [WIDTH-1:0] SEED_INIT = LCG_SEED_INIT
) (
  input  logic       clk,
  input  logic       rst,
  lcg_ctrl_if.master bus
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             enable_q, enable_d;
  logic             redo_q, redo_d;

  // Product carries above WIDTH never affect the result.
  logic unused_mult_upper;
  assign unused_mult_upper = ^bus.mult_result[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    enable_d = enable_q;
    redo_d   = redo_q;
    unique case (state_q)
      StStart: begin
        if (bus.seed_load) begin
          x_d = bus.seed_data;
        end else begin
          enable_d = 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (bus.seed_load) begin
          // Abort: any result arriving this cycle belongs to the old seed.
          x_d      = bus.seed_data;
          enable_d = 1'b0;
          redo_d   = 1'b1;
          state_d  = StDrain;
        end else if (bus.mult_done) begin
          x_d      = bus.mult_result[WIDTH-1:0] + C;
          enable_d = 1'b0;
          state_d  = StDrain;
        end
      end
      StDrain: begin
        if (bus.seed_load) begin
          x_d    = bus.seed_data;
          redo_d = 1'b1;
        end else if (!bus.mult_done) begin
          // Enable may only rise again once the multiplier has dropped done.
          state_d = redo_q ? StStart : StValid;
          redo_d  = 1'b0;
        end
      end
      StValid: begin
        if (bus.seed_load) begin
          x_d     = bus.seed_data;
          state_d = StStart;
        end else if (bus.rnd_ready) begin
          state_d = StStart;
        end
      end
      default: state_d = StStart;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StStart;
      x_q      <= SEED_INIT;
      enable_q <= 1'b0;
      redo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      enable_q <= enable_d;
      redo_q   <= redo_d;
    end
  end

  assign bus.rnd_valid         = (state_q == StValid);
  assign bus.rnd_data          = x_q;
  assign bus.mult_multiplicand = A;
  assign bus.mult_multiplier   = x_q;
  assign bus.mult_enable       = enable_q;

endmodule
